// File: rtl/audio_pwm_dac.sv
// rtl/audio_pwm_dac.sv - 1-bit audio DAC: PWM or first-order delta-sigma with volume shift and peak hold
module audio_pwm_dac #(
    parameter int CLK_DIV = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic [1:0] volume,
    input  logic [3:0] sample,
    input  logic       peak_clr,
    output logic       sample_ena,
    output logic       audio_out,
    output logic [3:0] peak
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (((CLK_DIV % 16) != 0) || (CLK_DIV < 16)) begin : g_bad_clk_div
        $error("audio_pwm_dac: CLK_DIV must be a multiple of 16 and at least 16");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [3:0]       acc_q, acc_d;
    logic [3:0]       level_q, level_d;
    logic             mode_q, mode_d;
    logic [3:0]       peak_q, peak_d;
    logic             sample_ena_q, sample_ena_d;
    logic             audio_out_q, audio_out_d;

    logic             capture;
    logic [3:0]       new_level;
    logic [4:0]       ds_sum;
    logic             pwm_bit;

    assign capture   = enable && (div_cnt_q == DIV_LAST);
    assign new_level = sample >> volume;
    assign ds_sum    = {1'b0, acc_q} + {1'b0, level_q};
    assign pwm_bit   = (pwm_cnt_q < level_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= DIV_LAST;
            pwm_cnt_q    <= '0;
            acc_q        <= '0;
            level_q      <= '0;
            mode_q       <= 1'b0;
            peak_q       <= '0;
            sample_ena_q <= 1'b0;
            audio_out_q  <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            acc_q        <= acc_d;
            level_q      <= level_d;
            mode_q       <= mode_d;
            peak_q       <= peak_d;
            sample_ena_q <= sample_ena_d;
            audio_out_q  <= audio_out_d;
        end
    end

    // Disabled: park the divider on its last count so the first enabled edge captures.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        pwm_cnt_d    = pwm_cnt_q;
        acc_d        = acc_q;
        sample_ena_d = 1'b0;
        audio_out_d  = 1'b0;
        if (!enable) begin
            div_cnt_d = DIV_LAST;
            pwm_cnt_d = '0;
            acc_d     = '0;
        end else begin
            div_cnt_d    = capture ? '0 : div_cnt_q + DIV_W'(1);
            pwm_cnt_d    = capture ? 4'd0 : pwm_cnt_q + 4'd1;
            acc_d        = ds_sum[3:0];
            sample_ena_d = capture;
            audio_out_d  = mode_q ? ds_sum[4] : pwm_bit;
        end
    end

    // Level and mode only move at the capture edge, so mid-period changes wait a period.
    always_comb begin
        level_d = level_q;
        mode_d  = mode_q;
        if (capture) begin
            level_d = new_level;
            mode_d  = mode;
        end
    end

    always_comb begin
        peak_d = peak_q;
        if (capture) begin
            if (peak_clr || (new_level > peak_q)) begin
                peak_d = new_level;
            end
        end else if (peak_clr) begin
            peak_d = '0;
        end
    end

    assign sample_ena = sample_ena_q;
    assign audio_out  = audio_out_q;
    assign peak       = peak_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// tb/tb_audio_pwm_dac.sv - scoreboard bench for audio_pwm_dac with an abstract reference model
module tb_audio_pwm_dac;

    localparam int CLK_DIV = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] volume = 2'd0;
    logic [3:0] sample = 4'd0;
    logic       peak_clr = 1'b0;
    logic       sample_ena;
    logic       audio_out;
    logic [3:0] peak;

    audio_pwm_dac #(.CLK_DIV(CLK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .volume     (volume),
        .sample     (sample),
        .peak_clr   (peak_clr),
        .sample_ena (sample_ena),
        .audio_out  (audio_out),
        .peak       (peak)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       sena;
        logic       out;
        logic [3:0] pk;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Model state: edges since the last capture (-1 = next enabled edge captures),
    // held level/mode/peak, and the running integer sum of levels fed to the modulator.
    int     phase;
    int     lvl;
    int     mq;
    int     pk;
    longint s_sum;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        phase = -1;
        lvl   = 0;
        mq    = 0;
        pk    = 0;
        s_sum = 0;
    endfunction

    function automatic bit next_cap();
        return (phase < 0) || (phase == CLK_DIV - 1);
    endfunction

    task automatic model_edge();
        exp_t e;
        int   pos;
        int   nl;
        bit   cap;
        e = '0;
        if (reset) begin
            model_reset();
        end else if (!enable) begin
            phase = -1;
            s_sum = 0;
            if (peak_clr) pk = 0;
            e.pk = 4'(pk);
        end else begin
            pos = (phase < 0) ? 0 : (phase % 16);
            if (mq == 0) e.out = (pos < lvl);
            else         e.out = ((s_sum + lvl) / 16) > (s_sum / 16);
            s_sum += lvl;
            cap = next_cap();
            if (cap) begin
                nl    = int'(sample) >> volume;
                lvl   = nl;
                mq    = int'(mode);
                pk    = (peak_clr || nl > pk) ? nl : pk;
                phase = 0;
            end else begin
                phase++;
                if (peak_clr) pk = 0;
            end
            e.sena = cap;
            e.pk   = 4'(pk);
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
    endtask

    task automatic capture_with(input logic [3:0] s, input logic clr);
        int guard;
        guard = 0;
        while (!next_cap() && guard < CLK_DIV + 2) begin
            step();
            guard++;
        end
        sample   = s;
        peak_clr = clr;
        step();
        peak_clr = 1'b0;
    endtask

    task automatic count_highs(input int n, output int c);
        c = 0;
        repeat (n) begin
            step();
            c += int'(audio_out);
        end
    endtask

    task automatic async_reset_check();
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("async_rst_sena", int'(sample_ena), 0);
        check("async_rst_out", int'(audio_out), 0);
        check("async_rst_peak", int'(peak), 0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{sena: sample_ena, out: audio_out, pk: peak};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard: got sena=%0b out=%0b peak=%h expected sena=%0b out=%0b peak=%h at %0t",
                             a.sena, a.out, a.pk, e.sena, e.out, e.pk, $time);
                end
            end
        end
    end

    initial begin : driver
        int c;
        int c2;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_sena", int'(sample_ena), 0);
        check("reset_out", int'(audio_out), 0);
        check("reset_peak", int'(peak), 0);
        enable = 1'b1; mode = 1'b0; volume = 2'd0; sample = 4'hA;
        step();
        step();
        reset = 1'b0;

        step();
        check("first_sena", int'(sample_ena), 1);
        count_highs(32, c);
        check("pwm_A_period", c, 20);
        count_highs(16, c);
        check("pwm_A_window0", c, 10);
        count_highs(16, c);
        check("pwm_A_window1", c, 10);
        check("sena_period", int'(sample_ena), 1);

        mode = 1'b1;
        capture_with(4'd3, 1'b0);
        count_highs(16, c);
        check("ds_3_window0", c, 3);
        count_highs(16, c);
        check("ds_3_window1", c, 3);
        capture_with(4'd0, 1'b0);
        count_highs(32, c);
        check("ds_0_period", c, 0);

        mode = 1'b0; volume = 2'd2;
        capture_with(4'hF, 1'b1);
        check("peak_vol2", int'(peak), 3);
        count_highs(10, c);
        mode = 1'b1; volume = 2'd0;
        count_highs(22, c2);
        check("toggle_mid_period", c + c2, 6);
        count_highs(16, c);
        check("ds_F_window", c, 15);

        mode = 1'b0;
        repeat (3) step();
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        check("peak_clr_mid0", int'(peak), 0);
        capture_with(4'h5, 1'b0);
        check("peak_5", int'(peak), 5);
        capture_with(4'hC, 1'b0);
        check("peak_C", int'(peak), 12);
        capture_with(4'h2, 1'b0);
        check("peak_C_hold", int'(peak), 12);
        capture_with(4'h7, 1'b1);
        check("peak_clr_cap7", int'(peak), 7);
        repeat (5) step();
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        check("peak_clr_mid1", int'(peak), 0);

        capture_with(4'hF, 1'b0);
        repeat (7) step();
        enable = 1'b0;
        step();
        check("dis_out", int'(audio_out), 0);
        check("dis_sena", int'(sample_ena), 0);
        repeat (5) step();
        check("dis_peak_kept", int'(peak), 15);
        enable = 1'b1;
        step();
        check("reen_sena", int'(sample_ena), 1);
        repeat (31) step();
        check("reen_gap", int'(sample_ena), 0);
        step();
        check("reen_period", int'(sample_ena), 1);

        mode = 1'b1;
        capture_with(4'h9, 1'b0);
        repeat (5) step();
        async_reset_check();
        step();
        step();
        reset = 1'b0;
        mode = 1'b0; sample = 4'hA; enable = 1'b1;
        step();
        check("rst_first_sena", int'(sample_ena), 1);
        count_highs(32, c);
        check("rst_pwm_A_period", c, 20);

        repeat (800) begin
            enable   = ($urandom_range(0, 19) != 0);
            mode     = 1'($urandom_range(0, 1));
            volume   = 2'($urandom_range(0, 3));
            sample   = 4'($urandom_range(0, 15));
            peak_clr = ($urandom_range(0, 39) == 0);
            step();
        end
        enable = 1'b1; peak_clr = 1'b0;
        repeat (CLK_DIV * 2) begin
            sample = 4'($urandom_range(0, 15));
            step();
        end

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
